// File: rtl/event_queue_ctrl.sv
// FIFO controller for a single-port event SRAM: valid/ready push port in, registered
// valid/ready pop port out, with alternating read/write priority under contention.
module event_queue_ctrl #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_event,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_event,
  input  logic             out_ready,
  output logic [AW-1:0]    sram_addr,
  output logic [WIDTH-1:0] sram_d_in,
  output logic             sram_wr_en,
  output logic             sram_sense_en,
  input  logic [WIDTH-1:0] sram_d_out,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             rd_inflight_q, rd_inflight_d;
  logic             out_valid_q, out_valid_d;
  logic             prio_rd_q, prio_rd_d;
  logic [WIDTH-1:0] out_event_q, out_event_d;

  logic rd_req;
  logic wr_fire;
  logic rd_issue;

  // A read is only requested when the output register is guaranteed free two cycles
  // later, so the capture of sram_d_out can never overwrite an unconsumed event.
  assign rd_req   = (level_q != '0) && !rd_inflight_q && (!out_valid_q || out_ready);
  assign in_ready = rst_n && (level_q != FULL_LEVEL) && !(rd_req && prio_rd_q);
  assign wr_fire  = in_valid && in_ready;
  assign rd_issue = rst_n && rd_req && !wr_fire;

  assign sram_wr_en    = wr_fire;
  assign sram_sense_en = rd_issue;
  assign sram_addr     = wr_fire ? wr_ptr_q : rd_ptr_q;
  assign sram_d_in     = in_event;

  assign out_valid = out_valid_q;
  assign out_event = out_event_q;
  assign level     = level_q;
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = !rst_n || ((level_q == '0) && !rd_inflight_q && !out_valid_q);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    rd_inflight_d = rd_issue;
    out_valid_d   = out_valid_q;
    out_event_d   = out_event_q;
    prio_rd_d     = prio_rd_q;

    // Explicit wrap so DEPTH need not be a power of two.
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
      level_d  = level_q + 1'b1;
    end else if (rd_issue) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
      level_d  = level_q - 1'b1;
    end

    if (rd_inflight_q) begin
      out_valid_d = 1'b1;
      out_event_d = sram_d_out;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Reads take priority next time only after losing a contended cycle to a write.
    if (wr_fire && rd_req) begin
      prio_rd_d = 1'b1;
    end else if (rd_issue) begin
      prio_rd_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples its
  // next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      prio_rd_q     <= 1'b0;
      out_event_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_inflight_q <= rd_inflight_d;
      out_valid_q   <= out_valid_d;
      prio_rd_q     <= prio_rd_d;
      out_event_q   <= out_event_d;
    end
  end

endmodule

// File: tb/tb_event_queue_ctrl.sv
// Self-checking bench for event_queue_ctrl: DEPTH=4 and DEPTH=3 instances, each with a
// behavioural SRAM, checked against a queue-based FIFO model.
module tb_event_queue_ctrl;

  logic clk;
  logic rst_n;
  logic sel;
  logic in_valid;
  logic [7:0] in_event;
  logic out_ready;

  logic a_in_valid, a_in_ready, a_out_valid, a_wr_en, a_se, a_full, a_empty;
  logic [7:0] a_out_event, a_d_in, a_d_out;
  logic [1:0] a_addr;
  logic [2:0] a_level;
  logic b_in_valid, b_in_ready, b_out_valid, b_wr_en, b_se, b_full, b_empty;
  logic [7:0] b_out_event, b_d_in, b_d_out;
  logic [1:0] b_addr;
  logic [2:0] b_level;

  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];

  assign a_in_valid = in_valid && !sel;
  assign b_in_valid = in_valid && sel;

  event_queue_ctrl #(.DEPTH(4), .WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_event(in_event),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_event(a_out_event),
    .out_ready(out_ready), .sram_addr(a_addr), .sram_d_in(a_d_in),
    .sram_wr_en(a_wr_en), .sram_sense_en(a_se), .sram_d_out(a_d_out),
    .level(a_level), .full(a_full), .empty(a_empty)
  );

  event_queue_ctrl #(.DEPTH(3), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_event(in_event),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_event(b_out_event),
    .out_ready(out_ready), .sram_addr(b_addr), .sram_d_in(b_d_in),
    .sram_wr_en(b_wr_en), .sram_sense_en(b_se), .sram_d_out(b_d_out),
    .level(b_level), .full(b_full), .empty(b_empty)
  );

  always @(posedge clk) begin
    if (a_wr_en) mem_a[a_addr] <= a_d_in;
    if (a_se)    a_d_out <= mem_a[a_addr];
    if (b_wr_en) mem_b[b_addr] <= b_d_in;
    if (b_se)    b_d_out <= mem_b[b_addr];
  end

  logic       o_in_ready, o_out_valid, o_wr_en, o_se, o_full, o_empty;
  logic [7:0] o_out_event, o_d_in;
  logic [1:0] o_addr;
  logic [2:0] o_level;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_out_event = sel ? b_out_event : a_out_event;
  assign o_wr_en     = sel ? b_wr_en     : a_wr_en;
  assign o_se        = sel ? b_se        : a_se;
  assign o_full      = sel ? b_full      : a_full;
  assign o_empty     = sel ? b_empty     : a_empty;
  assign o_d_in      = sel ? b_d_in      : a_d_in;
  assign o_addr      = sel ? b_addr      : a_addr;
  assign o_level     = sel ? b_level     : a_level;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the queue holds every accepted event not yet popped.
  logic [7:0] q [$];
  int         m_depth;
  logic [1:0] wr_addr_m, rd_addr_m;
  int         sram_cnt;
  int         n_pop;
  logic       top_wr, saw_wrap;

  logic       obs_push, obs_pop, obs_wr, obs_se, obs_ov, obs_ir, obs_full;
  logic [7:0] obs_oe;
  logic [1:0] obs_addr;
  logic [2:0] obs_level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q.delete();
    wr_addr_m = 2'd0;
    rd_addr_m = 2'd0;
    sram_cnt  = 0;
    top_wr    = 1'b0;
    saw_wrap  = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, then advance.
  task automatic step(input logic v, input logic [7:0] ev, input logic ordy);
    int qs;
    logic [7:0] exp_ev;
    in_valid  = v;
    in_event  = ev;
    out_ready = ordy;
    #1;
    obs_push  = v && o_in_ready;
    obs_pop   = o_out_valid && ordy;
    obs_wr    = o_wr_en;
    obs_se    = o_se;
    obs_ov    = o_out_valid;
    obs_oe    = o_out_event;
    obs_ir    = o_in_ready;
    obs_full  = o_full;
    obs_addr  = o_addr;
    obs_level = o_level;
    qs = q.size();
    check("wr_en_vs_fire", {31'd0, o_wr_en}, {31'd0, obs_push});
    check("single_port", {31'd0, o_wr_en && o_se}, 32'd0);
    check("empty", {31'd0, o_empty}, {31'd0, qs == 0});
    check("level", {29'd0, o_level}, sram_cnt);
    check("full", {31'd0, o_full}, {31'd0, sram_cnt == m_depth});
    if (o_wr_en || o_se) check("addr_range", {31'd0, int'(o_addr) < m_depth}, 32'd1);
    if (obs_push) begin
      check("wr_addr", {30'd0, o_addr}, {30'd0, wr_addr_m});
      check("d_in", {24'd0, o_d_in}, {24'd0, ev});
      if (o_addr == 2'd0 && top_wr) saw_wrap = 1'b1;
      top_wr = (int'(o_addr) == m_depth - 1);
      wr_addr_m = (int'(wr_addr_m) == m_depth - 1) ? 2'd0 : wr_addr_m + 2'd1;
    end
    if (o_se) begin
      check("rd_addr", {30'd0, o_addr}, {30'd0, rd_addr_m});
      rd_addr_m = (int'(rd_addr_m) == m_depth - 1) ? 2'd0 : rd_addr_m + 2'd1;
    end
    if (obs_pop) begin
      if (qs == 0) begin
        check("pop_underflow", 32'd1, 32'd0);
      end else begin
        exp_ev = q.pop_front();
        check("pop_data", {24'd0, o_out_event}, {24'd0, exp_ev});
      end
      n_pop++;
    end
    if (obs_push) q.push_back(ev);
    sram_cnt = sram_cnt + int'(obs_push) - int'(o_se);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] ev, input logic ordy);
    int k;
    k = 0;
    do begin
      step(1'b1, ev, ordy);
      k++;
    end while (!obs_push && k < 30);
    check("push_timeout", {31'd0, obs_push}, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      step(1'b0, 8'h00, 1'b1);
      k++;
    end
    check("drain_timeout", {31'd0, q.size() == 0}, 32'd1);
    step(1'b0, 8'h00, 1'b1);
  endtask

  logic wr_hist [40];
  logic se_hist [40];

  initial begin
    int pop_base;
    int idx;
    int k;
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b1; in_event = 8'hEE; out_ready = 1'b0;
    m_depth = 4; n_pop = 0;
    reset_model();
    #3;
    check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("rst_level", {29'd0, o_level}, 32'd0);
    check("rst_empty", {31'd0, o_empty}, 32'd1);
    check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single event latency: write at t, read issue at t+1, out_valid at t+3.
    step(1'b1, 8'hA5, 1'b1);
    check("t0_wr_en", {31'd0, obs_wr}, 32'd1);
    check("t0_addr", {30'd0, obs_addr}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("t1_sense_en", {31'd0, obs_se}, 32'd1);
    check("t1_addr", {30'd0, obs_addr}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("t2_out_valid", {31'd0, obs_ov}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("t3_out_valid", {31'd0, obs_ov}, 32'd1);
    check("t3_out_event", {24'd0, obs_oe}, 32'hA5);
    drain();

    // Fill with the consumer stalled.
    for (int i = 1; i <= 5; i++) push_one(8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h06, 1'b0);
      check("fill_held_off", {31'd0, obs_push}, 32'd0);
    end
    check("fill_out_valid", {31'd0, obs_ov}, 32'd1);
    check("fill_out_event", {24'd0, obs_oe}, 32'h01);
    check("fill_level", {29'd0, obs_level}, 32'd4);
    check("fill_full", {31'd0, obs_full}, 32'd1);
    check("fill_in_ready", {31'd0, obs_ir}, 32'd0);
    push_one(8'h06, 1'b1);
    drain();

    // Wrap and ordering with a randomly stalling consumer.
    saw_wrap = 1'b0; top_wr = 1'b0;
    pop_base = n_pop; idx = 0; k = 0;
    while ((idx < 12 || q.size() != 0) && k < 300) begin
      step(idx < 12, 8'(8'h10 + idx), 1'($urandom_range(0, 1)));
      if (obs_push) idx++;
      k++;
    end
    check("wrap_pushes", idx, 32'd12);
    check("wrap_pops", n_pop - pop_base, 32'd12);
    check("wrap_seen", {31'd0, saw_wrap}, 32'd1);
    drain();

    // Sustained contention settles into strict write/read alternation.
    push_one(8'h40, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      wr_hist[i] = obs_wr;
      se_hist[i] = obs_se;
    end
    for (int i = 30; i < 40; i++) begin
      check("contend_one_op", {31'd0, wr_hist[i] ^ se_hist[i]}, 32'd1);
      check("contend_alternate", {31'd0, wr_hist[i] ^ wr_hist[i-1]}, 32'd1);
    end
    drain();

    // Reset in the middle of a read discards everything stored or in flight.
    push_one(8'h31, 1'b0);
    push_one(8'h32, 1'b0);
    push_one(8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    in_valid = 1'b1; in_event = 8'h99; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, o_out_valid}, 32'd0);
    check("midrst_level", {29'd0, o_level}, 32'd0);
    check("midrst_empty", {31'd0, o_empty}, 32'd1);
    check("midrst_in_ready", {31'd0, o_in_ready}, 32'd0);
    check("midrst_strobes", {30'd0, o_wr_en, o_se}, 32'd0);
    @(negedge clk);
    check("midrst_in_ready_hold", {31'd0, o_in_ready}, 32'd0);
    rst_n = 1'b1;
    reset_model();
    pop_base = n_pop;
    push_one(8'h77, 1'b1);
    drain();
    check("post_rst_pops", n_pop - pop_base, 32'd1);

    // Non-power-of-two depth.
    sel = 1'b1; m_depth = 3;
    reset_model();
    step(1'b0, 8'h00, 1'b1);
    pop_base = n_pop; idx = 0; k = 0;
    while ((idx < 8 || q.size() != 0) && k < 200) begin
      step(idx < 8, 8'(8'h50 + idx), 1'($urandom_range(0, 1)));
      if (obs_push) idx++;
      k++;
    end
    check("np2_pushes", idx, 32'd8);
    check("np2_pops", n_pop - pop_base, 32'd8);
    check("np2_wrap_seen", {31'd0, saw_wrap}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
